// File: rtl/regfile_wb_arbiter_if.sv
// Producer-side request channels and register-file write port of the write-back arbiter.
interface regfile_wb_arbiter_if #(
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned NREG = 16
);
    logic            a_valid;
    logic            a_ready;
    logic [AW-1:0]   a_addr;
    logic [DW-1:0]   a_data;
    logic            b_valid;
    logic            b_ready;
    logic [AW-1:0]   b_addr;
    logic [DW-1:0]   b_data;
    logic            write;
    logic [AW-1:0]   wrAddr;
    logic [DW-1:0]   wrData;
    logic [NREG-1:0] pending;
    logic            err;

    // Arbiter view
    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready, write, wrAddr, wrData, pending, err
    );

    // Producers and register-file view
    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready, write, wrAddr, wrData, pending, err
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-source write-back arbiter driving the register-file write port: per-source circular
// FIFOs, round-robin grant, registered write strobe and an in-flight register mask.
module regfile_wb_arbiter #(
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned NREG  = 16,
    parameter int unsigned DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned AW1 = AW + 1;
    localparam logic [AW1-1:0] NREG_LIM = AW1'(NREG);
    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        mem_q  [2][DEPTH];
    entry_t        mem_d  [2][DEPTH];
    logic [PW-1:0] wptr_q [2];
    logic [PW-1:0] wptr_d [2];
    logic [PW-1:0] rptr_q [2];
    logic [PW-1:0] rptr_d [2];
    logic [CW-1:0] cnt_q  [2];
    logic [CW-1:0] cnt_d  [2];
    logic          prio_q, prio_d;
    logic          write_q, write_d;
    logic          err_q, err_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;

    logic [1:0]      in_valid, ready_c, accept, legal, push, pop, nonempty;
    entry_t          in_req [2];
    logic            grant_any, gsel;
    entry_t          head;
    logic [NREG-1:0] pending_c;

    assign in_valid  = {bus.b_valid, bus.a_valid};
    assign in_req[0] = '{addr: bus.a_addr, data: bus.a_data};
    assign in_req[1] = '{addr: bus.b_addr, data: bus.b_data};

    // Accept, arbitrate, pop/push and load the output register
    always_comb begin
        mem_d     = mem_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        cnt_d     = cnt_q;
        prio_d    = prio_q;
        write_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        err_d     = err_q;
        ready_c   = '0;
        accept    = '0;
        legal     = '0;
        push      = '0;
        pop       = '0;
        nonempty  = '0;
        grant_any = 1'b0;
        gsel      = 1'b0;
        head      = '0;

        for (int i = 0; i < 2; i++) begin
            nonempty[i] = (cnt_q[i] != '0);
            ready_c[i]  = reset && (cnt_q[i] != FULL_CNT);
            accept[i]   = in_valid[i] && ready_c[i];
            legal[i]    = ({1'b0, in_req[i].addr} < NREG_LIM);
            push[i]     = accept[i] && legal[i];
        end

        // Contention resolved by prio; a lone non-empty side always wins
        grant_any = |nonempty;
        gsel      = (&nonempty) ? prio_q : !nonempty[0];
        pop       = grant_any ? (gsel ? 2'b10 : 2'b01) : 2'b00;
        head      = mem_q[gsel][rptr_q[gsel]];

        if (grant_any) begin
            write_d   = 1'b1;
            wr_addr_d = head.addr;
            wr_data_d = head.data;
            prio_d    = !gsel;
        end

        err_d = err_q || (|(accept & ~legal));

        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                mem_d[i][wptr_q[i]] = in_req[i];
                wptr_d[i]           = wptr_q[i] + PW'(1);
            end
            if (pop[i]) begin
                rptr_d[i] = rptr_q[i] + PW'(1);
            end
            cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
        end
    end

    // Mask of registers still owed a write: live FIFO slots plus the strobe in flight
    always_comb begin
        pending_c = '0;
        for (int i = 0; i < 2; i++) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if (CW'(PW'(PW'(j) - rptr_q[i])) < cnt_q[i]) begin
                    pending_c = pending_c | (NREG'(1) << mem_q[i][j].addr);
                end
            end
        end
        if (write_q) begin
            pending_c = pending_c | (NREG'(1) << wr_addr_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                for (int unsigned j = 0; j < DEPTH; j++) begin
                    mem_q[i][j] <= '0;
                end
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            prio_q    <= 1'b0;
            write_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            prio_q    <= prio_d;
            write_q   <= write_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
        end
    end

    assign bus.a_ready = ready_c[0];
    assign bus.b_ready = ready_c[1];
    assign bus.write   = write_q;
    assign bus.wrAddr  = wr_addr_q;
    assign bus.wrData  = wr_data_q;
    assign bus.pending = pending_c;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized streaming traffic.
module tb_regfile_wb_arbiter;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned NREG  = 16;
    localparam int unsigned DEPTH = 2;
    localparam int          DEPTH_I = 2;
    localparam int          NREG_I  = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wlog_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DW(DW), .AW(AW), .NREG(NREG)) bus ();

    regfile_wb_arbiter #(.DW(DW), .AW(AW), .NREG(NREG), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state: what is queued per source and what the write port shows
    req_t            mq_a[$];
    req_t            mq_b[$];
    logic            m_prio, m_write, m_err;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_data;

    req_t        src_a[$];
    req_t        src_b[$];
    int unsigned gap_a = 0;
    int unsigned gap_b = 0;
    wlog_t       wlog[$];
    bit          saw_nr_a, saw_nr_b;
    int          exp_order[8] = '{1, 8, 2, 9, 3, 10, 4, 11};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq_a.delete();
        mq_b.delete();
        m_prio  = 1'b0;
        m_write = 1'b0;
        m_err   = 1'b0;
        m_addr  = '0;
        m_data  = '0;
    endtask

    function automatic logic [NREG-1:0] m_pending();
        logic [NREG-1:0] p;
        p = '0;
        foreach (mq_a[k]) p[mq_a[k].addr] = 1'b1;
        foreach (mq_b[k]) p[mq_b[k].addr] = 1'b1;
        if (m_write) p[m_addr] = 1'b1;
        return p;
    endfunction

    always @(negedge reset) model_clear();

    always @(posedge clk) cyc <= cyc + 1;

    // Model step: serve from the pre-edge queues, then enqueue what was accepted
    always @(posedge clk) begin
        if (reset) begin
            bit   acc_a, acc_b;
            req_t h;
            acc_a = bus.a_valid && (mq_a.size() < DEPTH_I);
            acc_b = bus.b_valid && (mq_b.size() < DEPTH_I);
            if (mq_a.size() > 0 && (mq_b.size() == 0 || !m_prio)) begin
                h = mq_a.pop_front();
                m_write = 1'b1; m_addr = h.addr; m_data = h.data; m_prio = 1'b1;
            end else if (mq_b.size() > 0) begin
                h = mq_b.pop_front();
                m_write = 1'b1; m_addr = h.addr; m_data = h.data; m_prio = 1'b0;
            end else begin
                m_write = 1'b0;
            end
            if (acc_a) begin
                if (int'(bus.a_addr) < NREG_I) mq_a.push_back(req_t'({bus.a_addr, bus.a_data}));
                else m_err = 1'b1;
            end
            if (acc_b) begin
                if (int'(bus.b_addr) < NREG_I) mq_b.push_back(req_t'({bus.b_addr, bus.b_data}));
                else m_err = 1'b1;
            end
        end
    end

    task automatic compare_all();
        chk("a_ready", bus.a_ready, reset && (mq_a.size() < DEPTH_I));
        chk("b_ready", bus.b_ready, reset && (mq_b.size() < DEPTH_I));
        chk("write",   bus.write,   m_write);
        chk("wrAddr",  bus.wrAddr,  m_addr);
        chk("wrData",  bus.wrData,  m_data);
        chk("pending", bus.pending, m_pending());
        chk("err",     bus.err,     m_err);
    endtask

    always @(negedge clk) compare_all();

    always @(negedge clk) begin
        if (reset && bus.write) wlog.push_back('{cyc: cyc, addr: bus.wrAddr, data: bus.wrData});
        if (reset && !bus.a_ready) saw_nr_a = 1'b1;
        if (reset && !bus.b_ready) saw_nr_b = 1'b1;
    end

    // Present queued requests, holding each until its handshake completes
    task automatic run_stream(input int max_cyc, input bit stop_on_drain, output bit drained);
        bit acc_a, acc_b, hold_a, hold_b;
        drained = 1'b0;
        hold_a  = 1'b0;
        hold_b  = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            if (!hold_a) begin
                if (src_a.size() > 0 && $urandom_range(0, 99) >= gap_a) begin
                    bus.a_valid = 1'b1; bus.a_addr = src_a[0].addr; bus.a_data = src_a[0].data;
                end else bus.a_valid = 1'b0;
            end
            if (!hold_b) begin
                if (src_b.size() > 0 && $urandom_range(0, 99) >= gap_b) begin
                    bus.b_valid = 1'b1; bus.b_addr = src_b[0].addr; bus.b_data = src_b[0].data;
                end else bus.b_valid = 1'b0;
            end
            @(negedge clk);
            acc_a = bus.a_valid && bus.a_ready;
            acc_b = bus.b_valid && bus.b_ready;
            @(posedge clk); #1;
            if (acc_a) void'(src_a.pop_front());
            if (acc_b) void'(src_b.pop_front());
            hold_a = bus.a_valid && !acc_a;
            hold_b = bus.b_valid && !acc_b;
            if (stop_on_drain && src_a.size() == 0 && src_b.size() == 0 &&
                mq_a.size() == 0 && mq_b.size() == 0 && !m_write) begin
                drained = 1'b1;
                break;
            end
        end
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit    ok;
        wlog_t bl[$];
        int    na;
        model_clear();
        bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;

        // Reset state
        #1;
        chk("rst_a_ready", bus.a_ready, 0);
        chk("rst_b_ready", bus.b_ready, 0);
        chk("rst_write",   bus.write,   0);
        chk("rst_pending", bus.pending, 0);
        chk("rst_err",     bus.err,     0);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_a_ready", bus.a_ready, 1);
        chk("post_rst_b_ready", bus.b_ready, 1);
        @(posedge clk); #1;

        // Single write: latency and pending window
        bus.a_valid = 1'b1; bus.a_addr = 5'd3; bus.a_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("sw_ready", bus.a_ready, 1);
        @(posedge clk); #1;
        bus.a_valid = 1'b0;
        @(negedge clk);
        chk("sw_pend_queued", bus.pending[3], 1);
        chk("sw_write_early", bus.write, 0);
        @(negedge clk);
        chk("sw_write", bus.write, 1);
        chk("sw_addr",  bus.wrAddr, 3);
        chk("sw_data",  bus.wrData, 32'hDEADBEEF);
        chk("sw_pend_inflight", bus.pending[3], 1);
        @(negedge clk);
        chk("sw_write_off", bus.write, 0);
        chk("sw_pend_off",  bus.pending[3], 0);
        @(posedge clk); #1;

        // Contention: both stream four writes
        do_reset();
        wlog.delete();
        saw_nr_a = 1'b0; saw_nr_b = 1'b0;
        gap_a = 0; gap_b = 0;
        for (int k = 1; k <= 4; k++) begin
            src_a.push_back(req_t'({5'(k), 32'hA000_0000 | 32'(k)}));
            src_b.push_back(req_t'({5'(k + 7), 32'hB000_0000 | 32'(k + 7)}));
        end
        run_stream(100, 1'b1, ok);
        chk("cont_drain", ok, 1);
        chk("cont_count", wlog.size(), 8);
        for (int k = 0; k < 8 && k < wlog.size(); k++) begin
            chk("cont_order", wlog[k].addr, exp_order[k]);
            chk("cont_data",  wlog[k].data,
                ((exp_order[k] < 8) ? 32'hA000_0000 : 32'hB000_0000) | 32'(exp_order[k]));
            chk("cont_no_idle", wlog[k].cyc, wlog[0].cyc + k);
        end
        chk("cont_a_ready_dropped", saw_nr_a, 1);
        chk("cont_b_ready_dropped", saw_nr_b, 1);

        // Backpressure across pointer wrap: B holds six writes against steady A traffic
        do_reset();
        wlog.delete();
        for (int k = 0; k < 8; k++) src_a.push_back(req_t'({5'(k), 32'hA5A5_0000 | 32'(k)}));
        for (int k = 0; k < 6; k++) src_b.push_back(req_t'({5'(k + 8), 32'h5B5B_0000 | 32'(k)}));
        run_stream(200, 1'b1, ok);
        chk("bp_drain", ok, 1);
        bl.delete();
        na = 0;
        foreach (wlog[k]) begin
            if (wlog[k].addr >= 8) bl.push_back(wlog[k]);
            else na++;
        end
        chk("bp_b_count", bl.size(), 6);
        chk("bp_a_count", na, 8);
        for (int k = 0; k < 6 && k < bl.size(); k++) begin
            chk("bp_b_addr", bl[k].addr, k + 8);
            chk("bp_b_data", bl[k].data, 32'h5B5B_0000 | 32'(k));
        end

        // Illegal address, then a legal write
        bus.a_valid = 1'b1; bus.a_addr = 5'd20; bus.a_data = 32'h1234_5678;
        @(negedge clk);
        chk("ill_ready", bus.a_ready, 1);
        @(posedge clk); #1;
        bus.a_valid = 1'b0;
        @(negedge clk);
        chk("ill_err",   bus.err, 1);
        chk("ill_write", bus.write, 0);
        chk("ill_pend",  bus.pending, 0);
        @(negedge clk);
        chk("ill_write2", bus.write, 0);
        chk("ill_err_sticky", bus.err, 1);
        @(posedge clk); #1;
        bus.a_valid = 1'b1; bus.a_addr = 5'd5; bus.a_data = 32'h0000_0055;
        @(negedge clk);
        @(posedge clk); #1;
        bus.a_valid = 1'b0;
        @(negedge clk);
        chk("ill_legal_pend", bus.pending[5], 1);
        @(negedge clk);
        chk("ill_legal_write", bus.write, 1);
        chk("ill_legal_addr",  bus.wrAddr, 5);
        chk("ill_legal_data",  bus.wrData, 32'h55);
        chk("ill_err_kept",    bus.err, 1);
        @(posedge clk); #1;

        // Reset in the middle of streaming
        for (int k = 0; k < 6; k++) begin
            src_a.push_back(req_t'({5'(k + 1), 32'hC000_0000 | 32'(k)}));
            src_b.push_back(req_t'({5'(k + 9), 32'hD000_0000 | 32'(k)}));
        end
        run_stream(4, 1'b0, ok);
        chk("mid_pre_write", bus.write, 1);
        src_a.delete();
        src_b.delete();
        reset = 1'b0;
        #1;
        chk("mid_write",   bus.write,   0);
        chk("mid_wrAddr",  bus.wrAddr,  0);
        chk("mid_wrData",  bus.wrData,  0);
        chk("mid_pending", bus.pending, 0);
        chk("mid_err",     bus.err,     0);
        chk("mid_a_ready", bus.a_ready, 0);
        chk("mid_b_ready", bus.b_ready, 0);
        compare_all();
        @(posedge clk); #1;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mid_quiet", bus.write, 0);
        end
        @(posedge clk); #1;
        bus.a_valid = 1'b1; bus.a_addr = 5'd6; bus.a_data = 32'h6666_6666;
        bus.b_valid = 1'b1; bus.b_addr = 5'd7; bus.b_data = 32'h7777_7777;
        @(negedge clk);
        @(posedge clk); #1;
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_first_write", bus.write, 1);
        chk("mid_first_addr",  bus.wrAddr, 6);
        @(negedge clk);
        chk("mid_second_addr", bus.wrAddr, 7);
        @(posedge clk); #1;

        // Randomized traffic with occasional illegal addresses
        for (int r = 0; r < 3; r++) begin
            do_reset();
            gap_a = $urandom_range(0, 70);
            gap_b = $urandom_range(0, 70);
            for (int k = 0; k < 120; k++) begin
                src_a.push_back(req_t'({($urandom_range(0, 99) < 8) ? 5'($urandom_range(16, 31))
                                                                   : 5'($urandom_range(0, 15)),
                                        32'($urandom)}));
                src_b.push_back(req_t'({($urandom_range(0, 99) < 8) ? 5'($urandom_range(16, 31))
                                                                   : 5'($urandom_range(0, 15)),
                                        32'($urandom)}));
            end
            run_stream(5000, 1'b1, ok);
            chk("rand_drain", ok, 1);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
